reflex_timer: RTL

Control and measurement core of the reflex tester. It waits a pseudo-random delay after a start press, lights the stimulus LED, and measures the time to the stop press in milliseconds as 4-digit BCD. It also tracks the best valid result. It drives the eight 4-bit digit inputs (seg0..seg7) of the eight-digit display driver directly downstream.

---
 rtl/reflex_pkg.sv | 27 ++
 rtl/bcd_counter4.sv | 45 ++++
 rtl/reflex_timer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/reflex_pkg.sv
// Shared types and constants for the reflex tester core.
package reflex_pkg;

    // Control states of the trial sequencer.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        MEASURE = 3'd2,
        DONE    = 3'd3,
        EARLY   = 3'd4
    } state_t;

    // 12-bit Fibonacci LFSR, x^12 + x^6 + x^4 + x + 1 (taps at bits 11, 5, 3, 0).
    localparam int          LFSR_W    = 12;
    localparam logic [11:0] LFSR_TAPS = 12'h829;
    localparam logic [11:0] LFSR_SEED = 12'h001;

    // Saturation value of the 4-digit BCD result and the digit shown after a false start.
    localparam logic [15:0] BCD_MAX     = 16'h9999;
    localparam logic [3:0]  EARLY_DIGIT = 4'hE;

    // Next LFSR value: shift left and feed back the XOR of the tapped bits.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear that holds at 9999.
module bcd_counter4
    import reflex_pkg::*;
(
    input  logic        ck,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] bcd,
    output logic        sat
);

    logic [15:0] bcd_plus1;
    logic        carry;

    assign sat = (bcd == BCD_MAX);

    // Ripple a +1 through the digits: a 9 rolls to 0 and passes the carry on.
    always_comb begin
        bcd_plus1 = bcd;
        carry     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (bcd[i*4 +: 4] == 4'd9) begin
                    bcd_plus1[i*4 +: 4] = 4'd0;
                end else begin
                    bcd_plus1[i*4 +: 4] = bcd[i*4 +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    // Counter register: clear wins over increment, increment is ignored once saturated.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            bcd <= 16'h0000;
        end else if (clr) begin
            bcd <= 16'h0000;
        end else if (inc && !sat) begin
            bcd <= bcd_plus1;
        end
    end

endmodule

// File: rtl/reflex_timer.sv
// Reflex tester core: random stimulus delay, millisecond BCD reaction timing, best-score tracking.
module reflex_timer
    import reflex_pkg::*;
#(
    parameter logic [26:0] TICK_MAX     = 27'd99_999,
    parameter logic [13:0] DELAY_MIN_MS = 14'd1000
) (
    input  logic        ck,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    output logic        led,
    output logic [3:0]  seg0,
    output logic [3:0]  seg1,
    output logic [3:0]  seg2,
    output logic [3:0]  seg3,
    output logic [3:0]  seg4,
    output logic [3:0]  seg5,
    output logic [3:0]  seg6,
    output logic [3:0]  seg7,
    output logic [2:0]  state_dbg,
    output logic [11:0] lfsr_dbg
);

    logic              start_meta, start_sync, start_prev, start_p;
    logic              stop_meta, stop_sync, stop_prev, stop_p;
    logic [LFSR_W-1:0] lfsr;
    logic [26:0]       tick_cnt;
    logic              tick;
    logic [13:0]       countdown;
    logic [13:0]       delay_load;
    state_t            state;
    logic              timeout;
    logic              done_first;
    logic [15:0]       best;
    logic              cnt_clr, cnt_inc, cnt_sat;
    logic [15:0]       cnt_bcd;
    logic              show_early;

    // Two-flop synchronizers plus a registered rising-edge pulse for each button.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            start_meta <= 1'b0;
            start_sync <= 1'b0;
            start_prev <= 1'b0;
            start_p    <= 1'b0;
            stop_meta  <= 1'b0;
            stop_sync  <= 1'b0;
            stop_prev  <= 1'b0;
            stop_p     <= 1'b0;
        end else begin
            start_meta <= start;
            start_sync <= start_meta;
            start_prev <= start_sync;
            start_p    <= start_sync & ~start_prev;
            stop_meta  <= stop;
            stop_sync  <= stop_meta;
            stop_prev  <= stop_sync;
            stop_p     <= stop_sync & ~stop_prev;
        end
    end

    // Free-running LFSR; the seed is non-zero so the sequence never locks up.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign tick       = (tick_cnt == TICK_MAX);
    assign delay_load = DELAY_MIN_MS + {3'b000, lfsr[10:0]};

    // Counter strobes: clear on the final WAIT tick (unless stop wins), count on MEASURE ticks.
    always_comb begin
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (state == WAIT && !stop_p && tick && countdown == 14'd1) begin
            cnt_clr = 1'b1;
        end
        if (state == MEASURE && tick) begin
            cnt_inc = 1'b1;
        end
    end

    bcd_counter4 u_cnt (
        .ck    (ck),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .bcd   (cnt_bcd),
        .sat   (cnt_sat)
    );

    // Trial sequencer; also owns the ms tick counter, which restarts on every state entry.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tick_cnt   <= 27'd0;
            countdown  <= 14'd0;
            led        <= 1'b0;
            timeout    <= 1'b0;
            done_first <= 1'b0;
            best       <= BCD_MAX;
        end else begin
            tick_cnt   <= tick ? 27'd0 : tick_cnt + 27'd1;
            done_first <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_p) begin
                        state     <= WAIT;
                        countdown <= delay_load;
                        tick_cnt  <= 27'd0;
                    end
                end
                WAIT: begin
                    if (stop_p) begin
                        state    <= EARLY;
                        tick_cnt <= 27'd0;
                    end else if (tick) begin
                        countdown <= countdown - 14'd1;
                        if (countdown == 14'd1) begin
                            state    <= MEASURE;
                            led      <= 1'b1;
                            tick_cnt <= 27'd0;
                        end
                    end
                end
                MEASURE: begin
                    if (cnt_sat) begin
                        state      <= DONE;
                        led        <= 1'b0;
                        timeout    <= 1'b1;
                        done_first <= 1'b1;
                        tick_cnt   <= 27'd0;
                    end else if (stop_p) begin
                        state      <= DONE;
                        led        <= 1'b0;
                        timeout    <= 1'b0;
                        done_first <= 1'b1;
                        tick_cnt   <= 27'd0;
                    end
                end
                DONE: begin
                    // BCD words order the same way as the numbers they encode.
                    if (done_first && !timeout && cnt_bcd < best) begin
                        best <= cnt_bcd;
                    end
                    if (start_p) begin
                        state     <= WAIT;
                        countdown <= delay_load;
                        tick_cnt  <= 27'd0;
                    end
                end
                EARLY: begin
                    if (start_p) begin
                        state     <= WAIT;
                        countdown <= delay_load;
                        tick_cnt  <= 27'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    led   <= 1'b0;
                end
            endcase
        end
    end

    assign show_early = (state == EARLY);

    assign seg0 = show_early ? EARLY_DIGIT : cnt_bcd[3:0];
    assign seg1 = show_early ? EARLY_DIGIT : cnt_bcd[7:4];
    assign seg2 = show_early ? EARLY_DIGIT : cnt_bcd[11:8];
    assign seg3 = show_early ? EARLY_DIGIT : cnt_bcd[15:12];
    assign seg4 = best[3:0];
    assign seg5 = best[7:4];
    assign seg6 = best[11:8];
    assign seg7 = best[15:12];

    assign state_dbg = state;
    assign lfsr_dbg  = lfsr;

endmodule
